mem_initiator: RTL and testbench
================================

MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, max consecutive stall cycles before a request is aborted (legal range 2..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a memory request.
REQ-005 SHALL have port req_ready  output  1  request accepted at this edge if req_valid is high.
REQ-006 SHALL have port req_wr  input  1  request type: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  16  byte address of the request.
REQ-008 SHALL have port req_wdata  input  16  write data.
REQ-009 SHALL have port resp_valid  output  1  one-cycle response pulse, with no backpressure.
REQ-010 SHALL have port resp_rdata  output  16  read data; 0 for writes and aborts.
REQ-011 SHALL have port resp_err  output  1  memory flagged an error, or the request timed out.
REQ-012 SHALL have port resp_timeout  output  1  the request was aborted by timeout.
REQ-013 SHALL have port mem_addr / mem_wdata  output  16 each  address and data driven to the memory.
REQ-014 SHALL have port mem_rd / mem_wr  output  1 each  read or write strobe to the memory.
REQ-015 SHALL have port mem_rdata  input  16  memory read data, combinational.
REQ-016 SHALL have ports mem_done, mem_stall, mem_err  input  1 each  memory handshake and status signals.
REQ-017 SHALL have port stall_count  output  16  saturating total of stalled cycles.

Function
REQ-018 SHALL hold requests in a 2-entry FIFO of {wr, addr, wdata}; req_ready = (count < 2), computed from registered count only.
REQ-019 A push when req_valid & req_ready SHALL enqueue at the edge; a request offered while full SHALL be held off even if a pop happens that cycle.
REQ-020 FSM states: IDLE (FIFO empty) and ISSUE (head outstanding).
REQ-021 IDLE->ISSUE SHALL occur on any push; ISSUE->IDLE SHALL occur on a pop that leaves the FIFO empty with no simultaneous push.
REQ-022 In ISSUE the outputs SHALL be driven combinationally from the head entry: mem_rd = ~wr, mem_wr = wr, mem_addr = addr, mem_wdata = wdata.
REQ-023 In IDLE mem_rd = mem_wr = 0, and mem_addr and mem_wdata = 0.
REQ-024 Head strobes, address and data SHALL stay stable every cycle until completion; the strobe is never dropped while mem_stall = 1.
REQ-025 Completion is an edge with mem_done = 1; at that edge the block SHALL pop the head and register the response.
REQ-026 On completion: resp_valid = 1 in the next cycle; resp_rdata = mem_rdata if a read, else 0; resp_err = mem_err; resp_timeout = 0.
REQ-027 The wait counter (8-bit) SHALL increment each ISSUE edge with mem_stall = 1 and clear on pop.
REQ-028 When the wait counter would reach TIMEOUT, the block SHALL pop the head without completion and pulse resp_valid with resp_err = 1, resp_timeout = 1, resp_rdata = 0.
REQ-029 If mem_done = 1 on the same edge as a timeout, completion SHALL take precedence.
REQ-030 The next FIFO entry SHALL be issued in the cycle after a pop, with no idle gap when the FIFO is non-empty.
REQ-031 Minimum latency SHALL be push at edge N, strobe in cycle N+1, resp_valid in cycle N+2 if mem_done is high in cycle N+1; one response per accepted request, in order.
REQ-032 stall_count SHALL increment on every edge with mem_stall = 1 and saturate at 16'hFFFF.
REQ-033 Odd addresses SHALL be forwarded unchanged; error detection is the memory's responsibility, reported via mem_err.

Reset
REQ-034 On rst at an edge: FIFO emptied, state IDLE, wait counter = 0, stall_count = 0, resp_valid / resp_err / resp_timeout = 0, resp_rdata = 0.
REQ-035 Reset mid-operation SHALL drop outstanding and queued requests with no response; mem_rd = mem_wr = 0 from the cycle after the reset edge.
REQ-036 While rst is high, req_ready = 0.

Verification
REQ-037 Read 0x0010, memory done immediately with mem_rdata = 0xBEEF -> mem_rd high for 1 cycle, then resp_valid with rdata 0xBEEF, err 0.
REQ-038 Write 0x0020 / 0x1234 with mem_stall high 3 cycles then done -> mem_wr, addr and data stable 4 cycles, one resp_valid, stall_count = 3.
REQ-039 Back-to-back pushes of 3 requests -> req_ready low after 2, third accepted after the first pop, responses in order, no idle strobe gap.
REQ-040 mem_stall held high with TIMEOUT = 4 -> pop after 4 stalled edges, resp_err = 1, resp_timeout = 1, next entry issued.
REQ-041 Read of 0x0011 with mem_err = 1 at done -> resp_err = 1, resp_timeout = 0.
REQ-042 rst asserted while a request is stalled with 1 queued -> no resp_valid, strobes low next cycle, req_ready = 1 after rst is released.

Source files
------------

// File: rtl/mem_initiator.sv
// Memory request initiator: 2-entry request FIFO feeding a single outstanding
// memory access, with per-request stall timeout and a saturating stall counter.
module mem_initiator #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_timeout,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_err,
  output logic [15:0] stall_count
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state, state_nxt;
  req_t          fifo [2];
  req_t          head_e;
  logic          head, tail;
  logic [1:0]    count;
  logic [CW-1:0] wait_cnt;
  logic          push, done_pop, to_pop, pop;

  // Ready depends only on the registered occupancy, so a pop never frees a slot early.
  assign req_ready = !rst && (count < 2'd2);
  assign push      = req_valid && req_ready;
  assign head_e    = fifo[head];
  assign done_pop  = (state == ISSUE) && mem_done;
  assign to_pop    = (state == ISSUE) && !mem_done && mem_stall &&
                     ((wait_cnt + CW'(1)) == CW'(TIMEOUT));
  assign pop       = done_pop || to_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (push) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_rd    = !head_e.wr;
        mem_wr    = head_e.wr;
        mem_addr  = head_e.addr;
        mem_wdata = head_e.wdata;
        if (pop && (count == 2'd1) && !push) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload storage needs no reset; occupancy and pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) fifo[tail] <= '{wr: req_wr, addr: req_addr, wdata: req_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= '0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      stall_count <= '0;
    end else begin
      if (pop) begin
        wait_cnt <= '0;
      end else if ((state == ISSUE) && mem_stall) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (mem_stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

  // Response is registered from whichever event popped the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      resp_valid   <= pop;
      resp_rdata   <= (done_pop && !head_e.wr) ? mem_rdata : '0;
      resp_err     <= done_pop ? mem_err : to_pop;
      resp_timeout <= to_pop;
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: directed scenarios plus random traffic, each cycle
// compared against a queue-based transaction model.
module tb_mem_initiator;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, resp_timeout;
  logic [15:0] resp_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_done, mem_stall, mem_err;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  mem_initiator #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_timeout(resp_timeout),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_err(mem_err), .stall_count(stall_count)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mreq_t;

  mreq_t       q[$];
  int          waitc;
  int          stalls;
  logic        e_valid, e_err, e_to;
  logic [15:0] e_rdata;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    waitc   = 0;
    stalls  = 0;
    e_valid = 1'b0;
    e_err   = 1'b0;
    e_to    = 1'b0;
    e_rdata = '0;
  endtask

  // One cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic r, input logic v, input logic w,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic dn, input logic st, input logic er,
                      input logic [15:0] rd);
    logic  busy, acc;
    mreq_t h;
    @(negedge clk);
    rst = r; req_valid = v; req_wr = w; req_addr = a; req_wdata = d;
    mem_done = dn; mem_stall = st; mem_err = er; mem_rdata = rd;
    #1;
    busy = (q.size() > 0);
    h = busy ? q[0] : '{wr: 1'b0, addr: 16'h0, wdata: 16'h0};
    check("req_ready", 32'(req_ready), 32'(!r && (q.size() < 2)));
    check("mem_rd", 32'(mem_rd), 32'(busy && !h.wr));
    check("mem_wr", 32'(mem_wr), 32'(busy && h.wr));
    check("mem_addr", 32'(mem_addr), busy ? 32'(h.addr) : 32'h0);
    check("mem_wdata", 32'(mem_wdata), busy ? 32'(h.wdata) : 32'h0);
    check("resp_valid", 32'(resp_valid), 32'(e_valid));
    check("resp_rdata", 32'(resp_rdata), 32'(e_rdata));
    check("resp_err", 32'(resp_err), 32'(e_err));
    check("resp_timeout", 32'(resp_timeout), 32'(e_to));
    check("stall_count", 32'(stall_count), 32'(stalls));
    if (r) begin
      model_reset();
    end else begin
      acc = v && (q.size() < 2);
      e_valid = 1'b0; e_err = 1'b0; e_to = 1'b0; e_rdata = '0;
      if (busy) begin
        if (dn) begin
          e_valid = 1'b1;
          e_rdata = h.wr ? 16'h0 : rd;
          e_err   = er;
          void'(q.pop_front());
          waitc = 0;
        end else if (st && (waitc + 1 == int'(TO))) begin
          e_valid = 1'b1;
          e_err   = 1'b1;
          e_to    = 1'b1;
          void'(q.pop_front());
          waitc = 0;
        end else if (st) begin
          waitc++;
        end
      end
      if (st && stalls < 65535) stalls++;
      if (acc) q.push_back('{wr: w, addr: a, wdata: d});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
    mem_done = 0; mem_stall = 0; mem_err = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
    idle(1);

    // Single read completing immediately.
    step(0, 1, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'hBEEF);
    idle(2);

    // Write with three stall cycles.
    step(0, 1, 1, 16'h0020, 16'h1234, 0, 0, 0, 16'h0);
    repeat (3) step(0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h5555);
    idle(2);

    // Three back-to-back requests; third held off until a slot frees.
    step(0, 1, 0, 16'h0100, 16'h0, 0, 0, 0, 16'h0);
    step(0, 1, 1, 16'h0102, 16'hA5A5, 0, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0104, 16'h0, 0, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0104, 16'h0, 1, 0, 0, 16'h1111);
    step(0, 1, 0, 16'h0104, 16'h0, 1, 0, 0, 16'h2222);
    step(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h3333);
    idle(2);

    // Timeout with a second entry queued behind it.
    step(0, 1, 0, 16'h0200, 16'h0, 0, 0, 0, 16'h0);
    step(0, 1, 1, 16'h0202, 16'h7777, 0, 1, 0, 16'h0);
    repeat (4) step(0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0);
    idle(2);

    // Odd-address read flagged by the memory.
    step(0, 1, 0, 16'h0011, 16'h0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'hCAFE);
    idle(2);

    // Reset while stalled with one queued.
    step(0, 1, 0, 16'h0300, 16'h0, 0, 0, 0, 16'h0);
    step(0, 1, 1, 16'h0302, 16'h9999, 0, 1, 0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h0);
    step(1, 1, 0, 16'h0304, 16'h0, 1, 1, 0, 16'h0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1),
           16'($urandom), 16'($urandom),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 9) == 0),
           16'($urandom));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
